// File: rtl/rx_word_assembler.sv
// Packs consecutive UART bytes into NB_WORD words, first byte in the LSBs.
// Ports: clock/reset, s_tick, rx_done_tick/din in; word_ready/overflow_clr in;
//   word_valid/word_out/byte_cnt/timeout_pulse/overflow out.
module rx_word_assembler #(
  parameter  int NB_DATA       = 8,
  parameter  int NB_WORD       = 32,
  parameter  int TIMEOUT_TICKS = 4096,
  parameter  int NB_TO         = 16,
  localparam int N             = NB_WORD / NB_DATA,
  localparam int NB_CNT        = $clog2(N)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] din,
  input  logic               word_ready,
  input  logic               overflow_clr,
  output logic               word_valid,
  output logic [NB_WORD-1:0] word_out,
  output logic [NB_CNT-1:0]  byte_cnt,
  output logic               timeout_pulse,
  output logic               overflow
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam logic [NB_TO-1:0] TO_LAST =
    NB_TO'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N - 1);

  state_t             state, state_n;
  logic [NB_CNT-1:0]  cnt_n;
  logic [NB_TO-1:0]   to_cnt, to_n;
  logic [NB_WORD-1:0] asm_reg, word_nxt;
  logic               complete;
  logic               expire;
  logic               can_load;

  always_comb begin
    state_n  = state;
    cnt_n    = byte_cnt;
    to_n     = to_cnt;
    word_nxt = asm_reg;
    complete = 1'b0;
    expire   = 1'b0;
    unique case (state)
      IDLE: begin
        to_n = '0;
        if (rx_done_tick) begin
          word_nxt[NB_DATA-1:0] = din;
          cnt_n   = NB_CNT'(1);
          state_n = COLLECT;
        end
      end
      COLLECT: begin
        if (rx_done_tick) begin
          word_nxt[int'(byte_cnt)*NB_DATA +: NB_DATA] = din;
          to_n = '0;
          if (byte_cnt == CNT_LAST) begin
            complete = 1'b1;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = byte_cnt + NB_CNT'(1);
          end
        end else if (TIMEOUT_TICKS > 0 && s_tick) begin
          // Expire on the tick that would make the count reach the limit.
          if (to_cnt == TO_LAST) begin
            expire  = 1'b1;
            cnt_n   = '0;
            to_n    = '0;
            state_n = IDLE;
          end else begin
            to_n = to_cnt + NB_TO'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      to_cnt   <= '0;
      asm_reg  <= '0;
    end else begin
      state    <= state_n;
      byte_cnt <= cnt_n;
      to_cnt   <= to_n;
      asm_reg  <= (complete || expire) ? '0 : word_nxt;
    end
  end

  // A draining buffer can take the new word on the same edge.
  assign can_load = !word_valid || word_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_valid    <= 1'b0;
      word_out      <= '0;
      timeout_pulse <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      timeout_pulse <= expire;
      if (complete && can_load) begin
        word_out   <= word_nxt;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
      if (complete && !can_load) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_word_assembler.sv
// Bench for rx_word_assembler: directed scenarios plus random traffic
// checked every cycle against a byte-queue model.
module tb_rx_word_assembler;

  localparam int TO = 8;

  logic        clock;
  logic        reset;
  logic        s_tick;
  logic        rx_done_tick;
  logic [7:0]  din;
  logic        word_ready;
  logic        overflow_clr;
  logic        word_valid;
  logic [31:0] word_out;
  logic [1:0]  byte_cnt;
  logic        timeout_pulse;
  logic        overflow;

  rx_word_assembler #(
    .NB_DATA(8),
    .NB_WORD(32),
    .TIMEOUT_TICKS(TO),
    .NB_TO(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .s_tick(s_tick),
    .rx_done_tick(rx_done_tick),
    .din(din),
    .word_ready(word_ready),
    .overflow_clr(overflow_clr),
    .word_valid(word_valid),
    .word_out(word_out),
    .byte_cnt(byte_cnt),
    .timeout_pulse(timeout_pulse),
    .overflow(overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int vectors;
  int miscompares;

  logic [7:0]  part[$];
  int          ticks;
  logic        m_valid;
  logic [31:0] m_word;
  logic        m_ovf;
  logic        m_pulse;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    ticks   = 0;
    m_valid = 1'b0;
    m_word  = '0;
    m_ovf   = 1'b0;
    m_pulse = 1'b0;
  endtask

  task automatic model_step(input logic rx, input logic [7:0] d,
                            input logic tk, input logic rdy,
                            input logic clr);
    logic        comp;
    logic [31:0] w;
    comp    = 1'b0;
    w       = '0;
    m_pulse = 1'b0;
    if (rx) begin
      part.push_back(d);
      ticks = 0;
      if (part.size() == 4) begin
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = part[k];
        comp = 1'b1;
        part.delete();
      end
    end else if (part.size() > 0 && tk) begin
      ticks++;
      if (ticks == TO) begin
        m_pulse = 1'b1;
        part.delete();
        ticks = 0;
      end
    end
    if (comp && m_valid && !rdy) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (comp) begin
      if (!m_valid || rdy) begin
        m_word  = w;
        m_valid = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_all();
    chk("word_valid", 32'(word_valid), 32'(m_valid));
    chk("word_out", word_out, m_word);
    chk("byte_cnt", 32'(byte_cnt), 32'(part.size()));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic cyc(input logic rx, input logic [7:0] d, input logic tk,
                     input logic rdy, input logic clr);
    rx_done_tick = rx;
    din          = d;
    s_tick       = tk;
    word_ready   = rdy;
    overflow_clr = clr;
    @(posedge clock);
    model_step(rx, d, tk, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] d, input logic rdy);
    cyc(1'b1, d, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    rx_done_tick = 1'b0;
    din          = '0;
    s_tick       = 1'b0;
    word_ready   = 1'b0;
    overflow_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;

    // 1) single word, consumer ready
    send(8'h11, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    send(8'h22, 1'b1);
    send(8'h33, 1'b1);
    send(8'h44, 1'b1);
    chk("t1_valid", 32'(word_valid), 32'd1);
    chk("t1_word", word_out, 32'h44332211);
    chk("t1_model", m_word, 32'h44332211);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t1_drained", 32'(word_valid), 32'd0);

    // 2) overflow while the buffer is stalled
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk("t2_word", word_out, 32'h04030201);
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_model_ovf", 32'(m_ovf), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t2_clr", 32'(overflow), 32'd0);

    // 3) drain A one cycle before B completes, then same-edge drain+load
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(8'hA1 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) send(8'hB1 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    send(8'hB4, 1'b1);
    chk("t3_word_b", word_out, 32'hB4B3B2B1);
    chk("t3_ovf_b", 32'(overflow), 32'd0);
    for (int i = 0; i < 3; i++) send(8'hC1 + 8'(i), 1'b0);
    send(8'hC4, 1'b1);
    chk("t3_word_c", word_out, 32'hC4C3C2C1);
    chk("t3_valid_c", 32'(word_valid), 32'd1);
    chk("t3_ovf_c", 32'(overflow), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // 4) timeout discards a partial word
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    for (int i = 0; i < TO; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_pulse", 32'(timeout_pulse), 32'd1);
    chk("t4_cnt", 32'(byte_cnt), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_pulse_off", 32'(timeout_pulse), 32'd0);
    send(8'h9A, 1'b0);
    send(8'hBC, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hF0, 1'b0);
    chk("t4_word", word_out, 32'hF0DEBC9A);

    // 5) byte on the expiring tick, then async reset mid-cycle
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < TO - 1; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    chk("t5_cnt", 32'(byte_cnt), 32'd3);
    chk("t5_no_pulse", 32'(timeout_pulse), 32'd0);
    chk("t5_valid", 32'(word_valid), 32'd1);
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(word_valid), 32'd0);
    chk("t5_rst_word", word_out, 32'h0);
    chk("t5_rst_cnt", 32'(byte_cnt), 32'd0);
    chk("t5_rst_pulse", 32'(timeout_pulse), 32'd0);
    chk("t5_rst_ovf", 32'(overflow), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;

    // random traffic: dense bytes, then sparse bytes to hit timeouts
    for (int i = 0; i < 4000; i++) begin
      logic rx, tk, rdy, clr;
      if (i < 2000) rx = ($urandom_range(0, 2) == 0);
      else rx = ($urandom_range(0, 19) == 0);
      tk  = ($urandom_range(0, 1) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      cyc(rx, 8'($urandom), tk, rdy, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
